patch_trigger_sequencer: RTL and testbench

- Controller for one observe/control patch point.
- Watches a group of observed signals and compares them against a programmed masked pattern.
- On a match, overrides a group of controlled signals with programmed values for a programmed number of cycles.
- Configuration arrives over a serial bit interface. The block sits between the patch configuration chain and the tapped design signals.

---
 rtl/patch_trigger_sequencer_pkg.sv | 43 ++++
 rtl/patch_trigger_sequencer_if.sv | 23 ++
 rtl/patch_trigger_sequencer_cfg_shifter.sv | 67 ++++++
 rtl/patch_trigger_sequencer.sv | 146 ++++++++++++++
 tb/tb_patch_trigger_sequencer.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/patch_trigger_sequencer_pkg.sv
// Shared state type and configuration-word layout helpers for patch_trigger_sequencer.
package patch_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    ACTIVE = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int DEF_OBS_W  = 4;
  localparam int DEF_CTRL_W = 5;
  localparam int DEF_DUR_W  = 8;

  // Field order inside the serial word, LSB first: match_val, match_mask, ovr_en, ovr_val, duration.
  function automatic int cfg_width(input int obs_w, input int ctrl_w, input int dur_w);
    return 2 * obs_w + 2 * ctrl_w + dur_w;
  endfunction

  function automatic int off_match_mask(input int obs_w);
    return obs_w;
  endfunction

  function automatic int off_ovr_en(input int obs_w);
    return 2 * obs_w;
  endfunction

  function automatic int off_ovr_val(input int obs_w, input int ctrl_w);
    return 2 * obs_w + ctrl_w;
  endfunction

  function automatic int off_duration(input int obs_w, input int ctrl_w);
    return 2 * obs_w + 2 * ctrl_w;
  endfunction

  localparam int OFF_MATCH_VAL  = 0;
  localparam int OFF_MATCH_MASK = DEF_OBS_W;
  localparam int OFF_OVR_EN     = 2 * DEF_OBS_W;
  localparam int OFF_OVR_VAL    = 2 * DEF_OBS_W + DEF_CTRL_W;
  localparam int OFF_DURATION   = 2 * DEF_OBS_W + 2 * DEF_CTRL_W;
  localparam int DEF_CFG_W      = 2 * DEF_OBS_W + 2 * DEF_CTRL_W + DEF_DUR_W;

endpackage

// File: rtl/patch_trigger_sequencer_if.sv
// Serial configuration handshake between the patch configuration chain and the sequencer.
interface patch_cfg_if;

  logic cfg_bit;
  logic cfg_valid;
  logic cfg_ready;
  logic cfg_done;

  modport master (
    output cfg_bit,
    output cfg_valid,
    input  cfg_ready,
    input  cfg_done
  );

  modport slave (
    input  cfg_bit,
    input  cfg_valid,
    output cfg_ready,
    output cfg_done
  );

endinterface

// File: rtl/patch_trigger_sequencer_cfg_shifter.sv
// Serial shadow register for the patch configuration word: collects bits LSB first,
// holds the completed word until the sequencer applies it, then pulses cfg_done.
module patch_cfg_shifter #(
  parameter int CFG_W = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_bit,
  input  logic             cfg_valid,
  input  logic             apply,
  output logic             cfg_ready,
  output logic             cfg_pending,
  output logic             cfg_done,
  output logic [CFG_W-1:0] cfg_word
);

  localparam int               CNT_W    = $clog2(CFG_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CFG_W - 1);

  logic [CFG_W-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             pending_q, pending_d;
  logic             done_q, done_d;
  logic             accept;

  // New bits enter at the top so the first bit received ends up at bit 0.
  always_comb begin
    accept    = cfg_valid && !pending_q;
    shadow_d  = shadow_q;
    bit_cnt_d = bit_cnt_q;
    pending_d = pending_q;
    done_d    = 1'b0;
    if (accept) begin
      shadow_d = {cfg_bit, shadow_q[CFG_W-1:1]};
      if (bit_cnt_q == LAST_BIT) begin
        bit_cnt_d = '0;
        pending_d = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end
    if (apply && pending_q) begin
      pending_d = 1'b0;
      done_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q  <= '0;
      bit_cnt_q <= '0;
      pending_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      bit_cnt_q <= bit_cnt_d;
      pending_q <= pending_d;
      done_q    <= done_d;
    end
  end

  assign cfg_ready   = !pending_q;
  assign cfg_pending = pending_q;
  assign cfg_done    = done_q;
  assign cfg_word    = shadow_q;

endmodule

// File: rtl/patch_trigger_sequencer.sv
// Observe/control patch point: masked pattern trigger overriding controlled signals for a duration.
// Optional macro PATCH_TRIGGER_SEQUENCER_AUTO_REARM_EN: DONE re-arms and an 8-bit hit_cnt port is added.
module patch_trigger_sequencer
  import patch_seq_pkg::*;
#(
  parameter int OBS_W  = 4,
  parameter int CTRL_W = 5,
  parameter int DUR_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  patch_cfg_if.slave        cfg,
  input  logic              arm,
  input  logic [OBS_W-1:0]  obs_in,
  input  logic [CTRL_W-1:0] sig_in,
  output logic [CTRL_W-1:0] sig_out,
  output logic              hit,
  output logic [1:0]        state_o
`ifdef PATCH_TRIGGER_SEQUENCER_AUTO_REARM_EN
  ,
  output logic [7:0]        hit_cnt
`endif
);

  localparam int CFG_W    = cfg_width(OBS_W, CTRL_W, DUR_W);
  localparam int MASK_LSB = off_match_mask(OBS_W);
  localparam int EN_LSB   = off_ovr_en(OBS_W);
  localparam int VAL_LSB  = off_ovr_val(OBS_W, CTRL_W);
  localparam int DUR_LSB  = off_duration(OBS_W, CTRL_W);

  state_e            state_q, state_d;
  logic [DUR_W-1:0]  dur_cnt_q, dur_cnt_d;
  logic [CTRL_W-1:0] ovr_act_q, ovr_act_d;
  logic              hit_q, hit_d;
  logic [CFG_W-1:0]  cfg_q, cfg_d;
  logic [CFG_W-1:0]  cfg_word;
  logic              cfg_pending;
  logic              apply;
  logic              match;

  logic [OBS_W-1:0]  match_val, match_mask;
  logic [CTRL_W-1:0] ovr_en, ovr_val;
  logic [DUR_W-1:0]  duration;

  assign match_val  = cfg_q[0 +: OBS_W];
  assign match_mask = cfg_q[MASK_LSB +: OBS_W];
  assign ovr_en     = cfg_q[EN_LSB +: CTRL_W];
  assign ovr_val    = cfg_q[VAL_LSB +: CTRL_W];
  assign duration   = cfg_q[DUR_LSB +: DUR_W];

  // An all-zero mask would match everything, so it is treated as "never trigger".
  assign match = (match_mask != '0) && (((obs_in ^ match_val) & match_mask) == '0);

  patch_cfg_shifter #(
    .CFG_W (CFG_W)
  ) u_cfg_shifter (
    .clk         (clk),
    .rst         (rst),
    .cfg_bit     (cfg.cfg_bit),
    .cfg_valid   (cfg.cfg_valid),
    .apply       (apply),
    .cfg_ready   (cfg.cfg_ready),
    .cfg_pending (cfg_pending),
    .cfg_done    (cfg.cfg_done),
    .cfg_word    (cfg_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      dur_cnt_q <= '0;
      ovr_act_q <= '0;
      hit_q     <= 1'b0;
      cfg_q     <= '0;
    end else begin
      state_q   <= state_d;
      dur_cnt_q <= dur_cnt_d;
      ovr_act_q <= ovr_act_d;
      hit_q     <= hit_d;
      cfg_q     <= cfg_d;
    end
  end

  // A zero duration makes ACTIVE sticky; otherwise dur_cnt counts the remaining override cycles.
  always_comb begin
    state_d   = state_q;
    dur_cnt_d = dur_cnt_q;
    case (state_q)
      IDLE: begin
        if (arm && !cfg_pending) state_d = ARMED;
      end
      ARMED: begin
        if (!arm) begin
          state_d = IDLE;
        end else if (match) begin
          state_d   = ACTIVE;
          dur_cnt_d = duration;
        end
      end
      ACTIVE: begin
        if (!arm) begin
          state_d = IDLE;
        end else if (duration != '0) begin
          dur_cnt_d = dur_cnt_q - 1'b1;
          if (dur_cnt_q == DUR_W'(1)) state_d = DONE;
        end
      end
      DONE: begin
        if (!arm) state_d = IDLE;
`ifdef PATCH_TRIGGER_SEQUENCER_AUTO_REARM_EN
        else state_d = ARMED;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // The active config may only change while no override can be in flight.
  always_comb begin
    apply     = cfg_pending && (state_q == IDLE || state_q == DONE);
    hit_d     = (state_q == ARMED) && arm && match;
    ovr_act_d = (state_d == ACTIVE) ? ovr_en : '0;
    cfg_d     = apply ? cfg_word : cfg_q;
    sig_out   = (sig_in & ~ovr_act_q) | (ovr_val & ovr_act_q);
  end

  assign hit     = hit_q;
  assign state_o = state_q;

`ifdef PATCH_TRIGGER_SEQUENCER_AUTO_REARM_EN
  logic [7:0] hit_cnt_q, hit_cnt_d;

  always_comb begin
    hit_cnt_d = hit_cnt_q;
    if (hit_d && hit_cnt_q != 8'hFF) hit_cnt_d = hit_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) hit_cnt_q <= '0;
    else     hit_cnt_q <= hit_cnt_d;
  end

  assign hit_cnt = hit_cnt_q;
`endif

endmodule

// File: tb/tb_patch_trigger_sequencer.sv
// Self-checking bench for patch_trigger_sequencer: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the patch point.
module tb_patch_trigger_sequencer;

  localparam int OBS_W  = 4;
  localparam int CTRL_W = 5;
  localparam int DUR_W  = 8;
  localparam int CFG_W  = 2 * OBS_W + 2 * CTRL_W + DUR_W;

`ifdef PATCH_TRIGGER_SEQUENCER_AUTO_REARM_EN
  localparam bit REARM = 1'b1;
`else
  localparam bit REARM = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic              arm;
  logic [OBS_W-1:0]  obs_in;
  logic [CTRL_W-1:0] sig_in;
  logic [CTRL_W-1:0] sig_out;
  logic              hit;
  logic [1:0]        state_o;
`ifdef PATCH_TRIGGER_SEQUENCER_AUTO_REARM_EN
  logic [7:0]        hit_cnt;
`endif

  patch_cfg_if cfg_bus ();

  patch_trigger_sequencer #(
    .OBS_W  (OBS_W),
    .CTRL_W (CTRL_W),
    .DUR_W  (DUR_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .cfg     (cfg_bus.slave),
    .arm     (arm),
    .obs_in  (obs_in),
    .sig_in  (sig_in),
    .sig_out (sig_out),
    .hit     (hit),
    .state_o (state_o)
`ifdef PATCH_TRIGGER_SEQUENCER_AUTO_REARM_EN
    ,
    .hit_cnt (hit_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: phase 0..3 = idle/armed/active/done, received bits kept in a queue.
  bit               m_bits[$];
  logic [CFG_W-1:0] m_shadow;
  logic [CFG_W-1:0] m_cfg;
  bit               m_pending, m_done, m_hit, m_ovr;
  int               m_phase, m_left, m_hitcnt;

  int n_vec  = 0;
  int n_fail = 0;

  bit              cur_arm;
  logic [OBS_W-1:0] cur_obs;
  logic [CTRL_W-1:0] cur_sig;
  int cnt_a, cnt_b;

  function automatic logic [CFG_W-1:0] mkWord(input logic [3:0] mv, input logic [3:0] mk,
                                              input logic [4:0] en, input logic [4:0] val,
                                              input logic [7:0] dur);
    return {dur, val, en, mk, mv};
  endfunction

  task automatic modelStep(input bit r, input bit b, input bit v, input bit a, input logic [3:0] o);
    logic [3:0] mv, mk;
    int  dur, nphase, nleft;
    bit  trig, apply;
    if (r) begin
      m_bits.delete();
      m_shadow = '0; m_cfg = '0;
      m_pending = 0; m_done = 0; m_hit = 0; m_ovr = 0;
      m_phase = 0; m_left = 0; m_hitcnt = 0;
      return;
    end
    mv   = m_cfg[3:0];
    mk   = m_cfg[7:4];
    dur  = int'(m_cfg[25:18]);
    trig = (mk != 4'd0) && (((o ^ mv) & mk) == 4'd0);
    nphase = m_phase;
    nleft  = m_left;
    m_hit  = 0;
    m_done = 0;
    case (m_phase)
      0: if (a && !m_pending) nphase = 1;
      1: if (!a) nphase = 0;
         else if (trig) begin
           nphase = 2; nleft = dur; m_hit = 1;
           if (m_hitcnt < 255) m_hitcnt++;
         end
      2: if (!a) nphase = 0;
         else if (dur != 0) begin
           nleft = m_left - 1;
           if (nleft == 0) nphase = 3;
         end
      default: if (!a) nphase = 0; else if (REARM) nphase = 1;
    endcase
    apply = m_pending && (m_phase == 0 || m_phase == 3);
    if (apply) begin
      m_cfg = m_shadow; m_pending = 0; m_done = 1;
    end else if (v && !m_pending) begin
      m_bits.push_back(b);
      if (m_bits.size() == CFG_W) begin
        for (int i = 0; i < CFG_W; i++) m_shadow[i] = m_bits[i];
        m_bits.delete();
        m_pending = 1;
      end
    end
    m_phase = nphase;
    m_left  = nleft;
    m_ovr   = (nphase == 2);
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] want);
    n_vec++;
    assert (got === want)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit b, input bit v, input bit a,
                               input logic [3:0] o, input logic [4:0] s);
    logic [4:0] en, val, exp_sig;
    rst = r; cfg_bus.cfg_bit = b; cfg_bus.cfg_valid = v;
    arm = a; obs_in = o; sig_in = s;
    modelStep(r, b, v, a, o);
    @(posedge clk);
    #1;
    en  = m_cfg[12:8];
    val = m_cfg[17:13];
    exp_sig = m_ovr ? ((s & ~en) | (val & en)) : s;
    checkOutput("cfg_ready", 8'(cfg_bus.cfg_ready), 8'(!m_pending));
    checkOutput("cfg_done", 8'(cfg_bus.cfg_done), 8'(m_done));
    checkOutput("hit", 8'(hit), 8'(m_hit));
    checkOutput("state_o", 8'(state_o), 8'(m_phase));
    checkOutput("sig_out", 8'(sig_out), 8'(exp_sig));
`ifdef PATCH_TRIGGER_SEQUENCER_AUTO_REARM_EN
    checkOutput("hit_cnt", hit_cnt, 8'(m_hitcnt));
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, cur_arm, cur_obs, cur_sig);
  endtask

  task automatic shiftWord(input logic [CFG_W-1:0] w, input int nbits);
    for (int i = 0; i < nbits; i++) applyStimulus(1'b0, w[i % CFG_W], 1'b1, cur_arm, cur_obs, cur_sig);
  endtask

  initial begin
    cur_arm = 0; cur_obs = '0; cur_sig = '0;
    $display("[TB] start");

    // Reset and first configuration load.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 5'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 5'd0);
    checkOutput("reset_state", 8'(state_o), 8'd0);
    checkOutput("reset_ready", 8'(cfg_bus.cfg_ready), 8'd1);
    shiftWord(mkWord(4'b1010, 4'b1111, 5'b00001, 5'b00001, 8'd3), CFG_W);
    checkOutput("ready_low_after_word", 8'(cfg_bus.cfg_ready), 8'd0);
    idle(2);

    // Trigger with duration 3.
    cur_arm = 1; idle(2);
    cnt_a = 0; cnt_b = 0;
    cur_obs = 4'b1010;
    applyStimulus(1'b0, 1'b0, 1'b0, cur_arm, cur_obs, cur_sig);
    cnt_a += int'(sig_out[0]); cnt_b += int'(hit);
    cur_obs = 4'b0000;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, cur_arm, cur_obs, cur_sig);
      cnt_a += int'(sig_out[0]); cnt_b += int'(hit);
    end
    checkOutput("ovr_cycles_dur3", 8'(cnt_a), 8'd3);
    checkOutput("hit_pulses_dur3", 8'(cnt_b), 8'd1);

    // Sticky override with duration 0.
    cur_arm = 0; idle(1);
    shiftWord(mkWord(4'b1010, 4'b1111, 5'b00001, 5'b00001, 8'd0), CFG_W);
    idle(2);
    cur_arm = 1; idle(2);
    cnt_a = 0;
    cur_obs = 4'b1010;
    applyStimulus(1'b0, 1'b0, 1'b0, cur_arm, cur_obs, cur_sig);
    cnt_a += int'(sig_out[0]);
    cur_obs = 4'b0000;
    for (int i = 0; i < 19; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, cur_arm, cur_obs, cur_sig);
      cnt_a += int'(sig_out[0]);
    end
    checkOutput("ovr_cycles_sticky", 8'(cnt_a), 8'd20);
    cur_arm = 0; idle(1);
    checkOutput("sticky_release_state", 8'(state_o), 8'd0);
    checkOutput("sticky_release_sig", 8'(sig_out), 8'(cur_sig));

    // Load a new word while ACTIVE; apply must wait for DONE.
    shiftWord(mkWord(4'b0011, 4'b1111, 5'b11111, 5'b10101, 8'd40), CFG_W);
    idle(2);
    cur_arm = 1; cur_sig = 5'b01010; idle(2);
    cur_obs = 4'b0011;
    applyStimulus(1'b0, 1'b0, 1'b0, cur_arm, cur_obs, cur_sig);
    cur_obs = 4'b0000;
    cnt_a = 0;
    for (int i = 0; i < CFG_W + 4; i++) begin
      applyStimulus(1'b0, mkWord(4'b0101, 4'b0000, 5'b11111, 5'b11111, 8'd4) >> i, 1'b1,
                    cur_arm, cur_obs, cur_sig);
      cnt_a += int'(cfg_bus.cfg_done);
    end
    checkOutput("still_active_after_load", 8'(state_o), 8'd2);
    for (int i = 0; i < 15; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, cur_arm, cur_obs, cur_sig);
      cnt_a += int'(cfg_bus.cfg_done);
    end
    checkOutput("done_pulses_deferred", 8'(cnt_a), 8'd1);

    // Zero mask never triggers.
    cur_arm = 0; idle(1);
    cur_arm = 1; idle(1);
    cnt_b = 0;
    for (int i = 0; i < 16; i++) begin
      cur_obs = 4'(i);
      applyStimulus(1'b0, 1'b0, 1'b0, cur_arm, cur_obs, cur_sig);
      cnt_b += int'(hit);
    end
    checkOutput("zero_mask_hits", 8'(cnt_b), 8'd0);
    checkOutput("zero_mask_state", 8'(state_o), 8'd1);

    // Reset mid-load, then a full second word.
    cur_arm = 0; cur_obs = '0; idle(1);
    shiftWord(mkWord(4'b1111, 4'b1111, 5'b11111, 5'b11111, 8'd9), 10);
    applyStimulus(1'b1, 1'b0, 1'b0, cur_arm, cur_obs, cur_sig);
    shiftWord(mkWord(4'b0110, 4'b0110, 5'b10100, 5'b10000, 8'd2), CFG_W);
    idle(2);
    cur_arm = 1; cur_sig = 5'b00110; idle(2);
    cur_obs = 4'b0110;
    applyStimulus(1'b0, 1'b0, 1'b0, cur_arm, cur_obs, cur_sig);
    checkOutput("second_word_override", 8'(sig_out), 8'(5'b10010));
    cur_obs = 4'b0000; idle(4);
    cur_obs = 4'b0110;
    applyStimulus(1'b0, 1'b0, 1'b0, cur_arm, cur_obs, cur_sig);
    cur_obs = 4'b0000; idle(4);
`ifdef PATCH_TRIGGER_SEQUENCER_AUTO_REARM_EN
    checkOutput("hit_cnt_two", hit_cnt, 8'd2);
`endif

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 29) == 0) cur_arm = !cur_arm;
      applyStimulus(1'($urandom_range(0, 299) == 0), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 2) == 0), cur_arm,
                    4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
